// File: rtl/ff_pkg.sv
// ----------------------------------------------------------------------------
// ff_pkg
//   Shared types and helpers for flip-flop excitation drivers.
//   - drv_state_t : driver FSM states (IDLE -> DRIVE -> SETTLE -> CHECK)
//   - sr_excite   : T-command to S/R excitation, don't-cares resolved to dc
//   - cnt_width   : width of a cycle counter able to hold max(a,b)
// ----------------------------------------------------------------------------
package ff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK
    } drv_state_t;

    // Counter width for the pulse/settle phase counters.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    localparam int unsigned DEF_PULSE_CYCLES  = 2;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam int unsigned DEF_CNT_W         = cnt_width(DEF_PULSE_CYCLES, DEF_SETTLE_CYCLES);

    // Returns {s, r} for toggle command t applied to present state q.
    function automatic logic [1:0] sr_excite(input logic t, input logic q, input logic dc);
        logic [1:0] sr;
        unique case ({t, q})
            2'b00:   sr = {1'b0, dc};
            2'b01:   sr = {dc, 1'b0};
            2'b10:   sr = 2'b10;
            default: sr = 2'b01;
        endcase
        // S=R=1 is illegal for an SR FF; keeping S preserves a valid hold at Q=1.
        if (sr == 2'b11) begin
            sr = 2'b10;
        end
        return sr;
    endfunction

endpackage

// File: rtl/t_to_sr_driver_enc.sv
// ----------------------------------------------------------------------------
// sr_excitation_enc
//   Combinational T -> S/R excitation encoder.
//   Ports:
//     t  in  toggle command
//     q  in  present state of the target flip-flop
//     s  out set drive
//     r  out reset drive
//   DC_VAL selects the value driven on excitation-table don't-cares.
// ----------------------------------------------------------------------------
module sr_excitation_enc
    import ff_pkg::*;
#(
    parameter bit DC_VAL = 1'b0
) (
    input  logic t,
    input  logic q,
    output logic s,
    output logic r
);

    logic [1:0] sr;

    always_comb begin
        sr = sr_excite(t, q, DC_VAL);
        s  = sr[1];
        r  = sr[0];
    end

endmodule

// File: rtl/t_to_sr_driver.sv
// ----------------------------------------------------------------------------
// t_to_sr_driver
//   Accepts T commands and drives S/R into an external SR flip-flop so that it
//   behaves as a T flip-flop. Tracks the expected Q, waits for the FF to
//   settle, then compares the returned Q and counts mismatches.
//   Ports:
//     clk, rst   clock (rising edge), synchronous active-high reset
//     t_valid    command valid
//     t_in       toggle command (1 = toggle, 0 = hold)
//     t_ready    command accepted when t_valid & t_ready
//     s_out      registered S drive
//     r_out      registered R drive
//     q_fb       Q returned by the external FF (sampled only in CHECK)
//     q_model    internal expected Q
//     busy       high outside IDLE
//     mismatch   one-cycle pulse after a failed check
//     err_count  saturating mismatch count
// ----------------------------------------------------------------------------
module t_to_sr_driver
    import ff_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 8,
    parameter bit          DC_VAL        = 1'b0,
    parameter bit          RESYNC        = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_valid,
    input  logic             t_in,
    output logic             t_ready,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_fb,
    output logic             q_model,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CNT_W = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    drv_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             q_model_q, q_model_d;
    logic             exp_q, exp_d;
    logic             mism_q, mism_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             enc_s, enc_r;

    sr_excitation_enc #(
        .DC_VAL(DC_VAL)
    ) u_enc (
        .t(t_in),
        .q(q_model_q),
        .s(enc_s),
        .r(enc_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            q_model_q <= 1'b0;
            exp_q     <= 1'b0;
            mism_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            r_q       <= r_d;
            q_model_q <= q_model_d;
            exp_q     <= exp_d;
            mism_q    <= mism_d;
            err_q     <= err_d;
        end
    end

    // S/R are registered: the value computed here appears on s_out/r_out the
    // cycle after the state transition that produced it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        q_model_d = q_model_q;
        exp_d     = exp_q;
        mism_d    = 1'b0;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (t_valid) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    s_d     = enc_s;
                    r_d     = enc_r;
                    exp_d   = q_model_q ^ t_in;
                end
            end
            DRIVE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    s_d   = s_q;
                    r_d   = r_q;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (q_fb != exp_q) begin
                    mism_d    = 1'b1;
                    err_d     = (&err_q) ? err_q : err_q + ERR_W'(1);
                    q_model_d = RESYNC ? q_fb : exp_q;
                end else begin
                    q_model_d = exp_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign t_ready   = (state_q == IDLE) & ~rst;
    assign busy      = (state_q != IDLE);
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign q_model   = q_model_q;
    assign mismatch  = mism_q;
    assign err_count = err_q;

    a_no_s_and_r: assert property (@(posedge clk) disable iff (rst) !(s_out && r_out));

endmodule

// File: tb/tb_t_to_sr_driver.sv
module tb_t_to_sr_driver;

    localparam int unsigned P = 2;
    localparam int unsigned S = 2;
    localparam int unsigned CHK = P + S + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_valid;
    logic       t_in;
    logic       q_fb     [2];
    logic       t_ready_o[2];
    logic       s_o      [2];
    logic       r_o      [2];
    logic       qm_o     [2];
    logic       busy_o   [2];
    logic       mism_o   [2];
    logic [7:0] err_a;
    logic [1:0] err_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state, per DUT (0: RESYNC=0 DC=0 ERR_W=8; 1: RESYNC=1 DC=1 ERR_W=2)
    bit          m_q     [2];
    bit          m_ff    [2];
    bit          m_stuck [2];
    bit          m_sv    [2];
    int unsigned m_err   [2];
    bit          c_resync[2] = '{1'b0, 1'b1};
    bit          c_dc    [2] = '{1'b0, 1'b1};
    int unsigned c_emax  [2] = '{255, 3};

    always #5 clk = ~clk;

    t_to_sr_driver #(
        .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .ERR_W(8), .DC_VAL(1'b0), .RESYNC(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .t_valid(t_valid), .t_in(t_in), .t_ready(t_ready_o[0]),
        .s_out(s_o[0]), .r_out(r_o[0]), .q_fb(q_fb[0]), .q_model(qm_o[0]),
        .busy(busy_o[0]), .mismatch(mism_o[0]), .err_count(err_a)
    );

    t_to_sr_driver #(
        .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .ERR_W(2), .DC_VAL(1'b1), .RESYNC(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .t_valid(t_valid), .t_in(t_in), .t_ready(t_ready_o[1]),
        .s_out(s_o[1]), .r_out(r_o[1]), .q_fb(q_fb[1]), .q_model(qm_o[1]),
        .busy(busy_o[1]), .mismatch(mism_o[1]), .err_count(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] err_of(input int k);
        return (k == 0) ? 32'(err_a) : 32'(err_b);
    endfunction

    // Excitation table: toggle from 0 sets, toggle from 1 resets; hold uses dc.
    function automatic logic [1:0] sr_ref(input bit t, input bit q, input bit dc);
        if (t) return q ? 2'b01 : 2'b10;
        if (q) return {dc, 1'b0};
        return {1'b0, dc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k]   = 1'b0;
            m_ff[k]  = 1'b0;
            m_err[k] = 0;
        end
    endtask

    task automatic do_reset(input int unsigned n);
        rst     = 1'b1;
        t_valid = 1'b0;
        q_fb[0] = 1'b0;
        q_fb[1] = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("d%0d.rst_ready", k), 32'(t_ready_o[k]), 0);
                check($sformatf("d%0d.rst_s", k), 32'(s_o[k]), 0);
                check($sformatf("d%0d.rst_r", k), 32'(r_o[k]), 0);
            end
        end
        rst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d.rst_qmodel", k), 32'(qm_o[k]), 0);
            check($sformatf("d%0d.rst_err", k), err_of(k), 0);
            check($sformatf("d%0d.rst_ready_after", k), 32'(t_ready_o[k]), 1);
            check($sformatf("d%0d.rst_busy", k), 32'(busy_o[k]), 0);
            check($sformatf("d%0d.rst_mism", k), 32'(mism_o[k]), 0);
        end
    endtask

    // One command through both DUTs; checks every cycle up to the return to IDLE.
    task automatic run_cmd(input bit t, input int unsigned gap, input bit glitch, input bit noise);
        logic [1:0] sr [2];
        bit         fb [2];
        bit         mm [2];
        bit         ex;
        t_valid = 1'b0;
        for (int i = 0; i < int'(gap); i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("d%0d.gap_ready", k), 32'(t_ready_o[k]), 1);
                check($sformatf("d%0d.gap_sr", k), {30'b0, s_o[k], r_o[k]}, 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            sr[k] = sr_ref(t, m_q[k], c_dc[k]);
            ex    = m_q[k] ^ t;
            if (sr[k][1])      m_ff[k] = 1'b1;
            else if (sr[k][0]) m_ff[k] = 1'b0;
            fb[k] = m_stuck[k] ? m_sv[k] : m_ff[k];
            mm[k] = (fb[k] != ex);
            if (mm[k]) begin
                if (m_err[k] < c_emax[k]) m_err[k]++;
                m_q[k] = c_resync[k] ? fb[k] : ex;
            end else begin
                m_q[k] = ex;
            end
            check($sformatf("d%0d.ready_pre", k), 32'(t_ready_o[k]), 1);
        end
        t_valid = 1'b1;
        t_in    = t;
        step();
        for (int c = 1; c <= int'(CHK); c++) begin
            for (int k = 0; k < 2; k++) begin
                logic [1:0] want;
                want = (c <= int'(P)) ? sr[k] : 2'b00;
                check($sformatf("d%0d.sr_c%0d", k, c), {30'b0, s_o[k], r_o[k]}, 32'(want));
                check($sformatf("d%0d.busy_c%0d", k, c), 32'(busy_o[k]), 1);
                check($sformatf("d%0d.ready_c%0d", k, c), 32'(t_ready_o[k]), 0);
                check($sformatf("d%0d.mism_c%0d", k, c), 32'(mism_o[k]), 0);
                if (c == int'(CHK))
                    q_fb[k] = fb[k];
                else if (glitch)
                    q_fb[k] = 1'($urandom);
            end
            if (noise) t_in = 1'($urandom);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d.mismatch", k), 32'(mism_o[k]), 32'(mm[k]));
            check($sformatf("d%0d.err_count", k), err_of(k), m_err[k]);
            check($sformatf("d%0d.q_model", k), 32'(qm_o[k]), 32'(m_q[k]));
            check($sformatf("d%0d.busy_end", k), 32'(busy_o[k]), 0);
            check($sformatf("d%0d.ready_end", k), 32'(t_ready_o[k]), 1);
        end
    endtask

    // Reset lands while S/R are being driven; the command must be dropped.
    task automatic reset_in_drive(input bit t);
        logic [1:0] sr [2];
        for (int k = 0; k < 2; k++) sr[k] = sr_ref(t, m_q[k], c_dc[k]);
        t_valid = 1'b1;
        t_in    = t;
        step();
        for (int k = 0; k < 2; k++)
            check($sformatf("d%0d.rd_sr_c1", k), {30'b0, s_o[k], r_o[k]}, 32'(sr[k]));
        step();
        rst     = 1'b1;
        t_valid = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d.rd_sr", k), {30'b0, s_o[k], r_o[k]}, 0);
            check($sformatf("d%0d.rd_busy", k), 32'(busy_o[k]), 0);
            check($sformatf("d%0d.rd_qmodel", k), 32'(qm_o[k]), 0);
            check($sformatf("d%0d.rd_err", k), err_of(k), 0);
            check($sformatf("d%0d.rd_ready_inrst", k), 32'(t_ready_o[k]), 0);
        end
        rst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("d%0d.rd_ready", k), 32'(t_ready_o[k]), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("d%0d.rd_mism", k), 32'(mism_o[k]), 0);
                check($sformatf("d%0d.rd_idle", k), 32'(busy_o[k]), 0);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        t_valid = 1'b0;
        t_in    = 1'b0;
        q_fb[0] = 1'b0;
        q_fb[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_stuck[k] = 1'b0;
            m_sv[k]    = 1'b0;
        end
        model_reset();

        do_reset(2);

        // Ideal FF, T = 1,1,0,1 back to back, then a hold from Q=1.
        run_cmd(1'b1, 0, 1'b0, 1'b0);
        run_cmd(1'b1, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 0, 1'b0, 1'b0);
        run_cmd(1'b1, 0, 1'b0, 1'b0);
        check("seq.q_model_d0", 32'(qm_o[0]), 1);
        run_cmd(1'b0, 0, 1'b0, 1'b1);
        check("hold_dc1.q_model_d1", 32'(qm_o[1]), 1);

        // FF stuck at 0: both resync policies, then saturation on the 2-bit counter.
        do_reset(2);
        for (int k = 0; k < 2; k++) begin
            m_stuck[k] = 1'b1;
            m_sv[k]    = 1'b0;
        end
        run_cmd(1'b1, 0, 1'b0, 1'b0);
        check("stuck.q_model_noresync", 32'(qm_o[0]), 1);
        check("stuck.q_model_resync", 32'(qm_o[1]), 0);
        for (int i = 0; i < 4; i++) run_cmd(1'b1, 0, 1'b1, 1'b1);
        check("stuck.err_saturated", err_of(1), 3);

        // Reset during DRIVE.
        for (int k = 0; k < 2; k++) m_stuck[k] = 1'b0;
        reset_in_drive(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                reset_in_drive(1'($urandom));
            end else begin
                for (int k = 0; k < 2; k++) begin
                    m_stuck[k] = ($urandom_range(0, 3) == 0);
                    m_sv[k]    = 1'($urandom);
                end
                run_cmd(1'($urandom), $urandom_range(0, 2), 1'($urandom), 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
